// File: rtl/uart_rx_process_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_process_pkg
//  Description : Shared types and helpers for the UART receive channel.
//                Optional feature macro: UART_PARITY_EN (8E1 framing).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_process_pkg;

  // Byte receiver states; the parity state exists only in 8E1 builds.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } rx_state_t;

  // Filler for the low half of a word closed on an odd byte count.
  localparam logic [7:0] c_PAD_BYTE = 8'h00;

  // Bit period in system clocks, rounded down.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage : uart_rx_process_pkg
`default_nettype wire

// File: rtl/uart_rx_process_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_process_byte
//  Description : RX synchroniser, bit timer and framing FSM. Emits one byte
//                with a valid or framing-error strobe per received frame.
//                Optional feature macro: UART_PARITY_EN (even parity check).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_process_byte
  import uart_rx_process_pkg::*;
#(
  parameter int DIV = 416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_idle
);

  localparam int             c_CW      = $clog2(DIV + 1);
  localparam logic [c_CW-1:0] c_FULL_M1 = c_CW'(DIV - 1);
  localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(DIV / 2 - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);

  logic [1:0]      r_sync;
  logic            r_rx_d;
  rx_state_t       r_state;
  rx_state_t       w_state_next;
  logic [c_CW-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            w_rx;
  logic            w_half;
  logic            w_full;
  logic            w_cnt_clr;
  logic            w_shift_en;
  logic            w_stop_ok;
`ifdef UART_PARITY_EN
  logic            r_par_err;
`endif

  assign w_rx   = r_sync[1];
  assign w_half = (r_cnt == c_HALF_M1);
  assign w_full = (r_cnt == c_FULL_M1);
  assign o_byte = r_shift;
  assign o_idle = (r_state == S_IDLE);

  // Synchroniser, bit timer, shift register and state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_rx_d  <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
`ifdef UART_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_rx_d  <= w_rx;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + c_CNT_ONE;
      if (r_state == S_START) begin
        r_bit <= '0;
      end else if (w_shift_en) begin
        r_bit <= r_bit + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {w_rx, r_shift[7:1]};
      end
`ifdef UART_PARITY_EN
      if (r_state == S_PARITY && w_full) begin
        r_par_err <= ^{r_shift, w_rx};
      end
`endif
    end
  end

  // Next-state decode and per-frame result strobes.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_stop_ok    = 1'b0;
    o_byte_valid = 1'b0;
    o_frame_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (r_rx_d && !w_rx) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_half) begin
          w_cnt_clr    = 1'b1;
          w_state_next = w_rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_full) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (w_full) begin
          w_cnt_clr    = 1'b1;
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_full) begin
          w_cnt_clr    = 1'b1;
          w_state_next = S_IDLE;
`ifdef UART_PARITY_EN
          w_stop_ok    = w_rx && !r_par_err;
`else
          w_stop_ok    = w_rx;
`endif
          o_byte_valid = w_stop_ok;
          o_frame_err  = !w_stop_ok;
        end
      end
      default: begin
        w_cnt_clr    = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule : uart_rx_process_byte
`default_nettype wire

// File: rtl/uart_rx_process.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_process
//  Description : UART receive channel. Packs bytes into 16-bit big-endian
//                words, frames messages by line-idle gap and presents them
//                through a word FIFO plus a message-length queue.
//                Optional feature macro: UART_PARITY_EN (8E1 framing).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_process
  import uart_rx_process_pkg::*;
#(
  parameter int CLK_HZ     = 48000000,
  parameter int BAUD       = 115200,
  parameter int GAP_BITS   = 20,
  parameter int MAX_WORDS  = 255,
  parameter int FIFO_DEPTH = 512,
  parameter int LEN_DEPTH  = 4
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic        UART_RX,
  input  logic        RD_REQ,
  input  logic        RD_REQ_LEN,
  output logic [15:0] FIFO_Q,
  output logic        GOT_FULL_MSG,
  output logic [7:0]  MSG_LEN_OUT,
  output logic        OVERFLOW
);

  localparam int              c_DIV       = calc_div(CLK_HZ, BAUD);
  localparam int              c_CW        = $clog2(c_DIV + 1);
  localparam int              c_GW        = $clog2(GAP_BITS + 1);
  localparam int              c_AW        = $clog2(FIFO_DEPTH);
  localparam int              c_LW        = $clog2(LEN_DEPTH);
  localparam logic [c_CW-1:0] c_DIV_M1    = c_CW'(c_DIV - 1);
  localparam logic [c_CW-1:0] c_CYC_ONE   = c_CW'(1);
  localparam logic [c_GW-1:0] c_GAP_M1    = c_GW'(GAP_BITS - 1);
  localparam logic [c_GW-1:0] c_GAP_ONE   = c_GW'(1);
  localparam logic [c_AW:0]   c_PTR_ONE   = (c_AW + 1)'(1);
  localparam logic [c_LW:0]   c_LPTR_ONE  = (c_LW + 1)'(1);
  localparam logic [7:0]      c_MAX_WORDS = 8'(MAX_WORDS);

  logic [7:0]      w_byte;
  logic            w_byte_valid;
  logic            w_frame_err;
  logic            w_rx_idle;

  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [c_AW:0]   r_wr_spec;
  logic [c_AW:0]   r_wr_commit;
  logic [c_AW:0]   r_rd;
  logic [7:0]      r_len_mem [LEN_DEPTH];
  logic [c_LW:0]   r_lwr;
  logic [c_LW:0]   r_lrd;

  logic            r_have_hi;
  logic [7:0]      r_hi;
  logic [7:0]      r_wcnt;
  logic            r_discard;
  logic            r_active;
  logic [c_CW-1:0] r_gap_cyc;
  logic [c_GW-1:0] r_gap_bits;
  logic            r_ovf;

  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_lenq_full;
  logic            w_lenq_empty;
  logic            w_gap_done;
  logic [7:0]      w_wcnt_inc;
  logic            w_wr_en;
  logic [15:0]     w_wr_data;
  logic            w_commit;
  logic [7:0]      w_commit_len;
  logic [c_AW:0]   w_commit_ptr;
  logic            w_drop;
  logic            w_ovf;

  uart_rx_process_byte #(
    .DIV (c_DIV)
  ) u_byte (
    .clk          (SYS_CLK),
    .rst          (RST),
    .i_rx         (UART_RX),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err),
    .o_idle       (w_rx_idle)
  );

  assign w_fifo_full  = (r_wr_spec[c_AW] != r_rd[c_AW]) &&
                        (r_wr_spec[c_AW-1:0] == r_rd[c_AW-1:0]);
  assign w_fifo_empty = (r_rd == r_wr_commit);
  assign w_lenq_full  = (r_lwr[c_LW] != r_lrd[c_LW]) &&
                        (r_lwr[c_LW-1:0] == r_lrd[c_LW-1:0]);
  assign w_lenq_empty = (r_lwr == r_lrd);
  assign w_gap_done   = r_active && w_rx_idle &&
                        (r_gap_cyc == c_DIV_M1) && (r_gap_bits == c_GAP_M1);
  assign w_wcnt_inc   = r_wcnt + 8'd1;
  assign w_commit_ptr = w_wr_en ? (r_wr_spec + c_PTR_ONE) : r_wr_spec;

  // Only committed words and lengths are visible on the read side.
  assign FIFO_Q       = w_fifo_empty ? 16'h0000 : r_mem[r_rd[c_AW-1:0]];
  assign GOT_FULL_MSG = !w_lenq_empty;
  assign MSG_LEN_OUT  = w_lenq_empty ? 8'h00 : r_len_mem[r_lrd[c_LW-1:0]];
  assign OVERFLOW     = r_ovf;

  // Packer decisions: word write, message close/commit, discard, overflow.
  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_data    = 16'h0000;
    w_commit     = 1'b0;
    w_commit_len = 8'h00;
    w_drop       = 1'b0;
    w_ovf        = 1'b0;
    if (w_frame_err) begin
      w_drop = !r_discard;
    end else if (w_byte_valid && !r_discard) begin
      if (r_have_hi) begin
        if (w_fifo_full) begin
          w_drop = 1'b1;
          w_ovf  = 1'b1;
        end else begin
          w_wr_en   = 1'b1;
          w_wr_data = {r_hi, w_byte};
          if (w_wcnt_inc == c_MAX_WORDS) begin
            if (w_lenq_full) begin
              w_drop = 1'b1;
              w_ovf  = 1'b1;
            end else begin
              w_commit     = 1'b1;
              w_commit_len = w_wcnt_inc;
            end
          end
        end
      end
    end else if (w_gap_done && !r_discard) begin
      if (r_have_hi) begin
        if (w_fifo_full || w_lenq_full) begin
          w_drop = 1'b1;
          w_ovf  = 1'b1;
        end else begin
          w_wr_en      = 1'b1;
          w_wr_data    = {r_hi, c_PAD_BYTE};
          w_commit     = 1'b1;
          w_commit_len = w_wcnt_inc;
        end
      end else if (r_wcnt != 8'h00) begin
        if (w_lenq_full) begin
          w_drop = 1'b1;
          w_ovf  = 1'b1;
        end else begin
          w_commit     = 1'b1;
          w_commit_len = r_wcnt;
        end
      end
    end
  end

  // Word RAM write port (speculative address).
  always_ff @(posedge SYS_CLK) begin
    if (w_wr_en) begin
      r_mem[r_wr_spec[c_AW-1:0]] <= w_wr_data;
    end
  end

  // Word FIFO pointers: speculative write, commit, and read.
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      r_wr_spec   <= '0;
      r_wr_commit <= '0;
      r_rd        <= '0;
    end else begin
      if (w_drop) begin
        r_wr_spec <= r_wr_commit;
      end else if (w_wr_en) begin
        r_wr_spec <= r_wr_spec + c_PTR_ONE;
      end
      if (w_commit) begin
        r_wr_commit <= w_commit_ptr;
      end
      if (RD_REQ && !w_fifo_empty) begin
        r_rd <= r_rd + c_PTR_ONE;
      end
    end
  end

  // Length queue: push on commit, pop on RD_REQ_LEN; both may happen together.
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      r_lwr <= '0;
      r_lrd <= '0;
      for (int i = 0; i < LEN_DEPTH; i++) begin
        r_len_mem[i] <= 8'h00;
      end
    end else begin
      if (w_commit) begin
        r_len_mem[r_lwr[c_LW-1:0]] <= w_commit_len;
        r_lwr <= r_lwr + c_LPTR_ONE;
      end
      if (RD_REQ_LEN && !w_lenq_empty) begin
        r_lrd <= r_lrd + c_LPTR_ONE;
      end
    end
  end

  // Open-message state: held high byte, word count, discard and activity flags.
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      r_have_hi <= 1'b0;
      r_hi      <= 8'h00;
      r_wcnt    <= 8'h00;
      r_discard <= 1'b0;
      r_active  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_ovf <= w_ovf;
      if (w_drop) begin
        r_have_hi <= 1'b0;
        r_wcnt    <= 8'h00;
        r_discard <= 1'b1;
      end else if (w_commit) begin
        r_have_hi <= 1'b0;
        r_wcnt    <= 8'h00;
      end else if (w_byte_valid && !r_discard) begin
        if (r_have_hi) begin
          r_have_hi <= 1'b0;
          r_wcnt    <= w_wcnt_inc;
        end else begin
          r_have_hi <= 1'b1;
          r_hi      <= w_byte;
        end
      end
      // A gap always ends the message, including one being dropped.
      if (w_gap_done) begin
        r_discard <= 1'b0;
      end
      if (w_gap_done || w_commit) begin
        r_active <= 1'b0;
      end else if (w_byte_valid || w_frame_err) begin
        r_active <= 1'b1;
      end
    end
  end

  // Idle-gap timer: counts whole bit-times while the line is idle after a byte.
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      r_gap_cyc  <= '0;
      r_gap_bits <= '0;
    end else if (!r_active || !w_rx_idle || w_gap_done) begin
      r_gap_cyc  <= '0;
      r_gap_bits <= '0;
    end else if (r_gap_cyc == c_DIV_M1) begin
      r_gap_cyc  <= '0;
      r_gap_bits <= r_gap_bits + c_GAP_ONE;
    end else begin
      r_gap_cyc <= r_gap_cyc + c_CYC_ONE;
    end
  end

endmodule : uart_rx_process
`default_nettype wire

// File: tb/tb_uart_rx_process.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_process
//  Description : Self-checking bench for uart_rx_process. Instance A uses a
//                512-word buffer, instance B a 16-word buffer. Expected
//                words and lengths are queued when bytes are sent and
//                compared when messages are read back.
//                Optional feature macro: UART_PARITY_EN (8E1 framing).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_process;

  localparam int CLK_HZ = 48000000;
  localparam int BAUD   = 6000000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int GAP    = 22;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        rx_a  = 1'b1;
  logic        rx_b  = 1'b1;
  logic        rd_a  = 1'b0;
  logic        rdl_a = 1'b0;
  logic        rd_b  = 1'b0;
  logic        rdl_b = 1'b0;
  logic [15:0] q_a, q_b;
  logic        got_a, got_b;
  logic [7:0]  len_a, len_b;
  logic        ovf_a, ovf_b;

  int total = 0;
  int bad   = 0;
  int ovf_cnt_a = 0;
  int ovf_cnt_b = 0;

  logic [15:0] exp_words_a[$];
  logic [15:0] exp_words_b[$];
  logic [7:0]  exp_len_a[$];
  logic [7:0]  exp_len_b[$];

  always #5 clk = ~clk;

  uart_rx_process #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .GAP_BITS(20), .MAX_WORDS(255),
    .FIFO_DEPTH(512), .LEN_DEPTH(4)
  ) u_dut_a (
    .SYS_CLK(clk), .RST(rst), .UART_RX(rx_a), .RD_REQ(rd_a),
    .RD_REQ_LEN(rdl_a), .FIFO_Q(q_a), .GOT_FULL_MSG(got_a),
    .MSG_LEN_OUT(len_a), .OVERFLOW(ovf_a)
  );

  uart_rx_process #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .GAP_BITS(20), .MAX_WORDS(255),
    .FIFO_DEPTH(16), .LEN_DEPTH(4)
  ) u_dut_b (
    .SYS_CLK(clk), .RST(rst), .UART_RX(rx_b), .RD_REQ(rd_b),
    .RD_REQ_LEN(rdl_b), .FIFO_Q(q_b), .GOT_FULL_MSG(got_b),
    .MSG_LEN_OUT(len_b), .OVERFLOW(ovf_b)
  );

  // Count OVERFLOW pulses on each instance.
  always @(posedge clk) begin
    if (ovf_a === 1'b1) ovf_cnt_a <= ovf_cnt_a + 1;
    if (ovf_b === 1'b1) ovf_cnt_b <= ovf_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rx_b = v; else rx_a = v;
    tick(DIV);
  endtask

  // flags[0]: force stop bit low; flags[1]: invert parity bit.
  task automatic send_byte(input bit sel, input logic [7:0] b, input logic [1:0] flags);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i]);
`ifdef UART_PARITY_EN
    drive_bit(sel, (^b) ^ flags[1]);
`endif
    drive_bit(sel, !flags[0]);
  endtask

  task automatic line_gap(input bit sel);
    if (sel) rx_b = 1'b1; else rx_a = 1'b1;
    tick(GAP * DIV);
  endtask

  task automatic push_msg(input bit sel, input logic [7:0] len);
    if (sel) exp_len_b.push_back(len); else exp_len_a.push_back(len);
  endtask

  task automatic push_word(input bit sel, input logic [15:0] w);
    if (sel) exp_words_b.push_back(w); else exp_words_a.push_back(w);
  endtask

  // Wait for a committed message, check its length and words, then release it.
  task automatic read_msg(input bit sel, input string tag);
    int          n;
    int          sz;
    logic [7:0]  el;
    logic [15:0] ew;
    n = 0;
    while (((sel ? got_b : got_a) !== 1'b1) && n < 600) begin
      tick(1);
      n++;
    end
    check({tag, "_got"}, sel ? got_b : got_a, 1);
    sz = sel ? exp_len_b.size() : exp_len_a.size();
    check({tag, "_sb_nonempty"}, (sz != 0), 1);
    if (sz == 0) return;
    if (sel) el = exp_len_b.pop_front(); else el = exp_len_a.pop_front();
    check({tag, "_len"}, sel ? len_b : len_a, el);
    for (int i = 0; i < int'(el); i++) begin
      if (sel) ew = exp_words_b.pop_front(); else ew = exp_words_a.pop_front();
      check({tag, "_word"}, sel ? q_b : q_a, ew);
      if (sel) rd_b = 1'b1; else rd_a = 1'b1;
      tick(1);
      rd_a = 1'b0;
      rd_b = 1'b0;
    end
    if (sel) rdl_b = 1'b1; else rdl_a = 1'b1;
    tick(1);
    rdl_a = 1'b0;
    rdl_b = 1'b0;
  endtask

  initial begin
    int n;

    // Reset values while reset is held.
    tick(3);
    check("rst_q", q_a, 16'h0000);
    check("rst_got", got_a, 0);
    check("rst_len", len_a, 8'h00);
    check("rst_ovf", ovf_a, 0);
    rst = 1'b0;
    tick(4);

    // 12 34 56 -> two words, lone byte padded.
    send_byte(0, 8'h12, 2'b00);
    send_byte(0, 8'h34, 2'b00);
    send_byte(0, 8'h56, 2'b00);
    push_msg(0, 8'd2); push_word(0, 16'h1234); push_word(0, 16'h5600);
    line_gap(0);
    read_msg(0, "odd3");

    // Two queued messages read in order.
    send_byte(0, 8'hAA, 2'b00);
    send_byte(0, 8'hBB, 2'b00);
    push_msg(0, 8'd1); push_word(0, 16'hAABB);
    line_gap(0);
    send_byte(0, 8'h01, 2'b00);
    send_byte(0, 8'h02, 2'b00);
    send_byte(0, 8'h03, 2'b00);
    send_byte(0, 8'h04, 2'b00);
    push_msg(0, 8'd2); push_word(0, 16'h0102); push_word(0, 16'h0304);
    line_gap(0);
    read_msg(0, "msgA");
    read_msg(0, "msgB");

    // Framing error discards the whole message.
    send_byte(0, 8'h11, 2'b00);
    send_byte(0, 8'h22, 2'b01);
    line_gap(0);
    check("ferr_nocommit", got_a, 0);
    send_byte(0, 8'h77, 2'b00);
    send_byte(0, 8'h88, 2'b00);
    push_msg(0, 8'd1); push_word(0, 16'h7788);
    line_gap(0);
    read_msg(0, "ferr_next");
    check("ferr_one_msg", got_a, 0);
    check("ferr_no_ovf", ovf_cnt_a, 0);

    // Short low glitch is not a start bit.
    rx_a = 1'b0;
    tick(2);
    line_gap(0);
    check("glitch_got", got_a, 0);

`ifdef UART_PARITY_EN
    // Bad parity on the first byte drops the message; good frames commit.
    send_byte(0, 8'h5B, 2'b10);
    send_byte(0, 8'h6C, 2'b00);
    line_gap(0);
    check("par_nocommit", got_a, 0);
    send_byte(0, 8'hD1, 2'b00);
    send_byte(0, 8'hD2, 2'b00);
    push_msg(0, 8'd1); push_word(0, 16'hD1D2);
    line_gap(0);
    read_msg(0, "par_good");
`endif

    // Reset mid-byte clears committed state; next frame is clean.
    send_byte(0, 8'h5A, 2'b00);
    send_byte(0, 8'hA5, 2'b00);
    line_gap(0);
    n = 0;
    while (got_a !== 1'b1 && n < 600) begin tick(1); n++; end
    check("prerst_got", got_a, 1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rst  = 1'b1;
    rx_a = 1'b1;
    tick(2);
    check("midrst_got", got_a, 0);
    check("midrst_len", len_a, 8'h00);
    check("midrst_q", q_a, 16'h0000);
    rst = 1'b0;
    tick(2 * DIV);
    send_byte(0, 8'h9A, 2'b00);
    send_byte(0, 8'hBC, 2'b00);
    push_msg(0, 8'd1); push_word(0, 16'h9ABC);
    line_gap(0);
    read_msg(0, "postrst");

    // 512 bytes with no gap: auto-close at 255 words, remainder closed by gap.
    for (int i = 0; i < 512; i++) send_byte(0, 8'(i), 2'b00);
    push_msg(0, 8'd255);
    for (int k = 0; k < 255; k++) push_word(0, {8'(2 * k), 8'(2 * k + 1)});
    push_msg(0, 8'd1); push_word(0, 16'hFEFF);
    line_gap(0);
    read_msg(0, "max1");
    read_msg(0, "max2");
    check("max_drained", got_a, 0);

    // Small buffer: 40-byte message overflows once, next message commits.
    for (int i = 0; i < 40; i++) send_byte(1, 8'(i + 8'h40), 2'b00);
    line_gap(1);
    check("ovf_nocommit", got_b, 0);
    check("ovf_pulses", ovf_cnt_b, 1);
    send_byte(1, 8'hC3, 2'b00);
    send_byte(1, 8'h3C, 2'b00);
    push_msg(1, 8'd1); push_word(1, 16'hC33C);
    line_gap(1);
    read_msg(1, "ovf_next");
    check("ovf_pulses_after", ovf_cnt_b, 1);
    check("a_never_ovf", ovf_cnt_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx_process
`default_nettype wire
